oam_dma: RTL and testbench

NES sprite OAM DMA engine on the CPU address bus, directly downstream of the CPU memory-address stage. It consumes that stage's `cpu_addr`/`cpu_read`/`cpu_write` and store data. On a CPU write to $4014 it drives the stage's `stall` input and takes over the bus. It then copies 256 bytes from page `$XX00` to the PPU OAM data port $2004, and muxes the final bus address, strobes and data seen by memory/PPU.

---
 rtl/oam_dma_pkg.sv | 9 +
 rtl/oam_dma_cpu_bus_mux.sv | 25 ++
 rtl/oam_dma.sv | 73 +++++++
 tb/tb_oam_dma.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared DMA state encoding and CPU bus map constants.
package oam_dma_pkg;
   typedef enum logic [2:0] {DMA_IDLE, DMA_HALT, DMA_ALIGN, DMA_READ, DMA_WRITE} dma_state_e;
   localparam logic [15:0] OAM_DMA_REG  = 16'h4014;
   localparam logic [15:0] OAM_DATA_REG = 16'h2004;
   localparam logic [15:0] NMI_VECTOR   = 16'hFFFA;
   localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
   localparam logic [15:0] IRQ_VECTOR   = 16'hFFFE;
endpackage

// File: rtl/oam_dma_cpu_bus_mux.sv
// cpu_bus_mux: selects CPU pass-through or DMA-driven bus signals by DMA state.
module cpu_bus_mux
   import oam_dma_pkg::*;
(
   input  dma_state_e  state,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_dout,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  data,
   output logic [15:0] bus_addr,
   output logic        bus_read,
   output logic        bus_write,
   output logic [7:0]  bus_dout
);
   logic idle;
   assign idle = state == DMA_IDLE;
   always_comb begin
      bus_addr  = idle ? cpu_addr : state == DMA_READ ? dma_addr : state == DMA_WRITE ? OAM_DATA_REG : cpu_addr;
      bus_read  = idle ? cpu_read : state == DMA_READ;
      bus_write = idle ? cpu_write : state != DMA_WRITE;
      bus_dout  = idle ? cpu_dout : data;
   end
endmodule

// File: rtl/oam_dma.sv
// oam_dma: NES sprite OAM DMA, copies page $XX00-$XXFF to $2004 on a write to $4014.
// Define OAM_DMA_ALIGN_EN to add the get/put phase and the extra ALIGN cycle.
module oam_dma
   import oam_dma_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_dout,
   input  logic [7:0]  bus_din,
   output logic        stall,
   output logic [15:0] bus_addr,
   output logic        bus_read,
   output logic        bus_write,
   output logic [7:0]  bus_dout,
   output logic        dma_busy
);
   dma_state_e state;
   logic [7:0] page, idx, data;
`ifdef OAM_DMA_ALIGN_EN
   logic phase;
   always_ff @(posedge clk) phase <= rst_n ? ~phase : 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= DMA_IDLE;
         page  <= 8'd0;
         idx   <= 8'd0;
         data  <= 8'd0;
      end else begin
         case (state)
            DMA_IDLE:
               if (!cpu_write && cpu_addr == OAM_DMA_REG) begin
                  page  <= cpu_dout;
                  idx   <= 8'd0;
                  state <= DMA_HALT;
               end
`ifdef OAM_DMA_ALIGN_EN
            DMA_HALT:  state <= phase ? DMA_ALIGN : DMA_READ;
            DMA_ALIGN: state <= DMA_READ;
`else
            DMA_HALT:  state <= DMA_READ;
`endif
            DMA_READ: begin
               data  <= bus_din;
               state <= DMA_WRITE;
            end
            DMA_WRITE: begin
               idx   <= idx + 8'd1;
               state <= idx == 8'hFF ? DMA_IDLE : DMA_READ;
            end
            default: state <= DMA_IDLE;
         endcase
      end
   end
   assign stall    = state != DMA_IDLE;
   assign dma_busy = state != DMA_IDLE;
   cpu_bus_mux u_mux (
      .state    (state),
      .cpu_addr (cpu_addr),
      .cpu_read (cpu_read),
      .cpu_write(cpu_write),
      .cpu_dout (cpu_dout),
      .dma_addr ({page, idx}),
      .data     (data),
      .bus_addr (bus_addr),
      .bus_read (bus_read),
      .bus_write(bus_write),
      .bus_dout (bus_dout)
   );
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed vectors and transfer sequences for oam_dma against a 64 KiB memory model.
module tb_oam_dma;
   import oam_dma_pkg::*;
`ifdef OAM_DMA_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   logic [15:0] cpu_addr = 16'h8000;
   logic cpu_read = 1'b0, cpu_write = 1'b1;
   logic [7:0] cpu_dout = 8'h00;
   logic [7:0] bus_din;
   logic stall, bus_read, bus_write, dma_busy;
   logic [15:0] bus_addr;
   logic [7:0] bus_dout;
   logic [7:0] mem [0:65535];
   logic tb_phase = 1'b0;
   int checks = 0, errors = 0;

   oam_dma dut (
      .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_read(cpu_read),
      .cpu_write(cpu_write), .cpu_dout(cpu_dout), .bus_din(bus_din), .stall(stall),
      .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write),
      .bus_dout(bus_dout), .dma_busy(dma_busy)
   );

   assign bus_din = mem[bus_addr];
   always #5 clk = ~clk;
   always @(posedge clk) tb_phase <= rst_n ? ~tb_phase : 1'b0;

   typedef struct {
      logic [15:0] addr; logic rd; logic wr; logic [7:0] dout;
      logic [15:0] e_addr; logic e_rd; logic e_wr; logic [7:0] e_dout; logic e_stall;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic int exp_len(input bit p);
      return 513 + ((ALIGN && p) ? 1 : 0);
   endfunction

   // HALT sees the phase after the trigger edge, i.e. the inverse of tb_phase just before it.
   task automatic trigger(input logic [7:0] pg, input bit want_phase);
      @(negedge clk);
      while (tb_phase == want_phase) @(negedge clk);
      cpu_addr = OAM_DMA_REG; cpu_write = 1'b0; cpu_read = 1'b0; cpu_dout = pg;
      #1;
      check("trig_passthru", {bus_addr, bus_write, bus_dout}, {OAM_DMA_REG, 1'b0, pg});
      check("trig_stall_pre", stall, 1'b0);
      @(posedge clk);
      #1 cpu_write = 1'b1; cpu_addr = 16'h8000;
   endtask

   task automatic run_xfer(input logic [7:0] pg, input int len, input bit glitch);
      int cyc = 0, nrd = 0, nwr = 0, bad = 0;
      logic [15:0] last_rd = 16'h0;
      logic [7:0] last_wd = 8'h0;
      bit zero_hit = 1'b0;
      forever begin
         @(negedge clk);
         if (glitch) begin cpu_write = 1'b1; cpu_addr = 16'h8000; end
         #1;
         if (!stall) break;
         cyc++;
         if (cyc > 600) break;
         if (dma_busy !== 1'b1) bad++;
         if (cyc == 1 && (bus_read || !bus_write)) bad++;
         if (bus_read) begin
            if (bus_addr !== {pg, nrd[7:0]} || !bus_write) bad++;
            if (bus_addr == 16'h0000) zero_hit = 1'b1;
            last_rd = bus_addr;
            if (glitch && nrd == 10) begin
               cpu_write = 1'b0; cpu_addr = OAM_DMA_REG; cpu_dout = 8'h33;
            end
            nrd++;
         end
         if (!bus_write) begin
            if (bus_addr !== OAM_DATA_REG || bus_dout !== mem[{pg, nwr[7:0]}]) bad++;
            last_wd = bus_dout;
            nwr++;
         end
      end
      check("xfer_len", cyc, len);
      check("xfer_reads", nrd, 256);
      check("xfer_writes", nwr, 256);
      check("xfer_seq_errs", bad, 0);
      check("xfer_zero_addr", zero_hit, 1'b0);
      check("xfer_last_read", last_rd, {pg, 8'hFF});
      check("xfer_last_data", last_wd, mem[{pg, 8'hFF}]);
      check("xfer_busy_after", dma_busy, 1'b0);
      check("xfer_passthru_after", bus_addr, cpu_addr);
   endtask

   initial begin
      vec_t vecs[6];
      int n, cyc;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = 8'(i);
      vecs[0] = '{16'h4013, 1'b0, 1'b0, 8'hAA, 16'h4013, 1'b0, 1'b0, 8'hAA, 1'b0};
      vecs[1] = '{16'h4015, 1'b0, 1'b0, 8'h55, 16'h4015, 1'b0, 1'b0, 8'h55, 1'b0};
      vecs[2] = '{16'h4014, 1'b1, 1'b1, 8'h12, 16'h4014, 1'b1, 1'b1, 8'h12, 1'b0};
      vecs[3] = '{16'h0200, 1'b1, 1'b1, 8'h00, 16'h0200, 1'b1, 1'b1, 8'h00, 1'b0};
      vecs[4] = '{16'h2004, 1'b0, 1'b0, 8'h7E, 16'h2004, 1'b0, 1'b0, 8'h7E, 1'b0};
      vecs[5] = '{16'h4014, 1'b0, 1'b1, 8'h02, 16'h4014, 1'b0, 1'b1, 8'h02, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", stall, 1'b0);
      check("rst_busy", dma_busy, 1'b0);
      check("rst_passthru", {bus_addr, bus_read, bus_write}, {16'h8000, 1'b0, 1'b1});
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         cpu_addr = vecs[i].addr; cpu_read = vecs[i].rd; cpu_write = vecs[i].wr; cpu_dout = vecs[i].dout;
         #1;
         check("vec_addr", bus_addr, vecs[i].e_addr);
         check("vec_read", bus_read, vecs[i].e_rd);
         check("vec_write", bus_write, vecs[i].e_wr);
         check("vec_dout", bus_dout, vecs[i].e_dout);
         @(posedge clk);
         #1;
         check("vec_stall", {stall, dma_busy}, {2{vecs[i].e_stall}});
      end
      cpu_addr = 16'h8000; cpu_read = 1'b0; cpu_write = 1'b1;

      trigger(8'h02, 1'b0);
      run_xfer(8'h02, exp_len(1'b0), 1'b0);
      trigger(8'h02, 1'b1);
      run_xfer(8'h02, exp_len(1'b1), 1'b0);
      trigger(8'hFF, 1'b0);
      run_xfer(8'hFF, exp_len(1'b0), 1'b0);
      trigger(8'h05, 1'b0);
      run_xfer(8'h05, exp_len(1'b0), 1'b1);

      trigger(8'h03, 1'b0);
      n = 0; cyc = 0;
      while (n < 100 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (!bus_write && bus_addr == OAM_DATA_REG) n++;
      end
      check("midrst_reached", n, 100);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_stall", stall, 1'b0);
      check("midrst_busy", dma_busy, 1'b0);
      check("midrst_passthru", {bus_addr, bus_read, bus_write}, {16'h8000, 1'b0, 1'b1});
      rst_n = 1'b1;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (!bus_write || stall) n++;
      end
      check("midrst_no_more_dma", n, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
